// File: rtl/inst_sram_axi_rd_bridge_if.sv
// Bus bundles used by the instruction-side read bridge.
//
// inst_sram_if : SRAM-like instruction fetch port.
//   master = fetch stage (drives req/wr/size/wstrb/addr/wdata)
//   slave  = bridge (returns addr_ok/data_ok/rdata and the AR ID in use)
//
// axi_rd_if : AXI4 read-address and read-data channels.
//   master = bridge (drives AR channel and rready)
//   slave  = interconnect (drives arready and the R channel)

interface inst_sram_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  axi_arid;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, axi_arid
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, axi_arid
    );
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-side SRAM-like to AXI4 read bridge.
//
// Every read request accepted from the fetch stage becomes one single-beat
// AXI read. Up to MAX_OUTST reads may be in flight; since one fixed ID is
// used, R data returns in order and is handed back as a one-cycle
// data_ok pulse with the registered data.
//
// Ports:
//   clk    : clock
//   resetn : synchronous, active-low reset
//   sram   : SRAM-like fetch port (slave side)
//   axi    : AXI4 AR/R channels (master side)
//
// Parameters:
//   MAX_OUTST : accepted-but-not-returned read limit, 1..3
//   ARID_VAL  : constant AXI ID used for instruction reads

module inst_sram_axi_rd_bridge #(
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [3:0]  ARID_VAL  = 4'h0
) (
    input  logic        clk,
    input  logic        resetn,
    inst_sram_if.slave  sram,
    axi_rd_if.master    axi
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } ar_state_t;

    ar_state_t   state;
    ar_state_t   state_next;
    logic [1:0]  cnt;
    logic [1:0]  cnt_next;
    logic        addr_ok;
    logic        r_hs;
    logic [31:0] araddr_q;
    logic [1:0]  arsize_q;
    logic        data_ok_q;
    logic [31:0] rdata_q;

    // Inputs that carry no meaning for an instruction read bridge.
    logic unused_inputs;
    assign unused_inputs = ^{sram.inst_sram_wstrb, sram.inst_sram_wdata,
                             axi.rid, axi.rresp, axi.rlast};

    // R is only accepted while something is outstanding; a stray beat with
    // nothing in flight is left untouched.
    assign axi.rready = (cnt != 2'd0);
    assign r_hs       = axi.rvalid & axi.rready;

    // Next-state logic for the AR channel. A request is only accepted while
    // no address is pending on AR and the outstanding window has room.
    always_comb begin
        state_next = state;
        addr_ok    = 1'b0;
        case (state)
            AR_IDLE: begin
                addr_ok = sram.inst_sram_req & ~sram.inst_sram_wr & (cnt < MAX_CNT);
                if (addr_ok) begin
                    state_next = AR_SEND;
                end
            end
            AR_SEND: begin
                if (axi.arready) begin
                    state_next = AR_IDLE;
                end
            end
            default: state_next = AR_IDLE;
        endcase
    end

    // Outstanding-read counter: accept and return in the same cycle cancel.
    always_comb begin
        cnt_next = cnt;
        case ({addr_ok, r_hs})
            2'b10:   cnt_next = cnt + 2'd1;
            2'b01:   cnt_next = cnt - 2'd1;
            default: cnt_next = cnt;
        endcase
    end

    // State, counter and the latched AR fields. Address and size are only
    // captured on acceptance so they stay stable while AR waits for arready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= AR_IDLE;
            cnt      <= 2'd0;
            araddr_q <= 32'd0;
            arsize_q <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (addr_ok) begin
                araddr_q <= sram.inst_sram_addr;
                arsize_q <= sram.inst_sram_size;
            end
        end
    end

    // Returned data is registered, so data_ok follows the R handshake by
    // one cycle and back-to-back beats give back-to-back pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            data_ok_q <= r_hs;
            if (r_hs) begin
                rdata_q <= axi.rdata;
            end
        end
    end

    assign sram.inst_sram_addr_ok = addr_ok;
    assign sram.inst_sram_data_ok = data_ok_q;
    assign sram.inst_sram_rdata   = rdata_q;
    assign sram.axi_arid          = ARID_VAL;

    // arvalid is a decode of the registered state, so it rises the cycle
    // after acceptance and drops the cycle after the AR handshake.
    assign axi.arvalid = (state == AR_SEND);
    assign axi.arid    = ARID_VAL;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, arsize_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Directed self-checking bench for inst_sram_axi_rd_bridge.
//
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled on the falling edge, so each "cycle" below is one clock period
// as seen by the design.

module tb_inst_sram_axi_rd_bridge;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    inst_sram_if sram_bus ();
    axi_rd_if    axi_bus ();

    inst_sram_axi_rd_bridge #(
        .MAX_OUTST (2),
        .ARID_VAL  (4'h0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sram   (sram_bus),
        .axi    (axi_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive every bench-controlled input for the coming cycle.
    task automatic applyStimulus(input logic req, input logic wr,
                                 input logic [31:0] addr, input logic arready,
                                 input logic rvalid, input logic [31:0] rdata);
        sram_bus.inst_sram_req   = req;
        sram_bus.inst_sram_wr    = wr;
        sram_bus.inst_sram_size  = 2'b10;
        sram_bus.inst_sram_wstrb = 4'h0;
        sram_bus.inst_sram_addr  = addr;
        sram_bus.inst_sram_wdata = 32'h0;
        axi_bus.arready          = arready;
        axi_bus.rvalid           = rvalid;
        axi_bus.rdata            = rdata;
        axi_bus.rid              = 4'h0;
        axi_bus.rresp            = 2'b00;
        axi_bus.rlast            = 1'b1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) nextCycle();

        // ---------------- reset state ----------------
        sample();
        checkOutput("rst_arvalid", 32'(axi_bus.arvalid), 32'd0);
        checkOutput("rst_araddr", axi_bus.araddr, 32'h0);
        checkOutput("rst_arsize", 32'(axi_bus.arsize), 32'd0);
        checkOutput("rst_rready", 32'(axi_bus.rready), 32'd0);
        checkOutput("rst_data_ok", 32'(sram_bus.inst_sram_data_ok), 32'd0);
        checkOutput("rst_rdata", sram_bus.inst_sram_rdata, 32'h0);
        checkOutput("const_arlen", 32'(axi_bus.arlen), 32'd0);
        checkOutput("const_arburst", 32'(axi_bus.arburst), 32'd1);
        checkOutput("const_arid", 32'(axi_bus.arid), 32'd0);
        checkOutput("const_axi_arid", 32'(sram_bus.axi_arid), 32'd0);
        resetn = 1'b1;
        nextCycle();

        // ---------------- single read ----------------
        $display("[TB] single read");
        applyStimulus(1'b1, 1'b0, 32'h1C00_0000, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t1_addr_ok_T0", 32'(sram_bus.inst_sram_addr_ok), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t1_arvalid_T1", 32'(axi_bus.arvalid), 32'd1);
        checkOutput("t1_araddr_T1", axi_bus.araddr, 32'h1C00_0000);
        checkOutput("t1_arsize_T1", 32'(axi_bus.arsize), 32'd2);
        checkOutput("t1_rready_T1", 32'(axi_bus.rready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0280_0C0C);
        sample();
        checkOutput("t1_arvalid_T2", 32'(axi_bus.arvalid), 32'd0);
        checkOutput("t1_data_ok_T2", 32'(sram_bus.inst_sram_data_ok), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t1_data_ok_T3", 32'(sram_bus.inst_sram_data_ok), 32'd1);
        checkOutput("t1_rdata_T3", sram_bus.inst_sram_rdata, 32'h0280_0C0C);
        checkOutput("t1_cnt_T3", 32'(dut.cnt), 32'd0);
        nextCycle();
        sample();
        checkOutput("t1_data_ok_T4", 32'(sram_bus.inst_sram_data_ok), 32'd0);
        nextCycle();

        // ---------------- arready stall ----------------
        $display("[TB] arready stall");
        applyStimulus(1'b1, 1'b0, 32'h1C00_0010, 1'b0, 1'b0, 32'h0);
        sample();
        checkOutput("t2_addr_ok_T0", 32'(sram_bus.inst_sram_addr_ok), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h1C00_0014, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sample();
            checkOutput("t2_stall_arvalid", 32'(axi_bus.arvalid), 32'd1);
            checkOutput("t2_stall_araddr", axi_bus.araddr, 32'h1C00_0010);
            checkOutput("t2_stall_addr_ok", 32'(sram_bus.inst_sram_addr_ok), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 32'h1C00_0014, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t2_hs_arvalid", 32'(axi_bus.arvalid), 32'd1);
        checkOutput("t2_hs_addr_ok", 32'(sram_bus.inst_sram_addr_ok), 32'd0);
        nextCycle();
        sample();
        checkOutput("t2_after_addr_ok", 32'(sram_bus.inst_sram_addr_ok), 32'd1);
        checkOutput("t2_after_arvalid", 32'(axi_bus.arvalid), 32'd0);
        checkOutput("t2_after_rready", 32'(axi_bus.rready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t2_ar2_arvalid", 32'(axi_bus.arvalid), 32'd1);
        checkOutput("t2_ar2_araddr", axi_bus.araddr, 32'h1C00_0014);
        checkOutput("t2_ar2_cnt", 32'(dut.cnt), 32'd2);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0A0_A0A0);
        sample();
        checkOutput("t2_r1_data_ok", 32'(sram_bus.inst_sram_data_ok), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB1B1_B1B1);
        sample();
        checkOutput("t2_r2_data_ok", 32'(sram_bus.inst_sram_data_ok), 32'd1);
        checkOutput("t2_r2_rdata", sram_bus.inst_sram_rdata, 32'hA0A0_A0A0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        sample();
        checkOutput("t2_r3_data_ok", 32'(sram_bus.inst_sram_data_ok), 32'd1);
        checkOutput("t2_r3_rdata", sram_bus.inst_sram_rdata, 32'hB1B1_B1B1);
        checkOutput("t2_r3_rready", 32'(axi_bus.rready), 32'd0);
        nextCycle();
        sample();
        checkOutput("t2_r4_data_ok", 32'(sram_bus.inst_sram_data_ok), 32'd0);
        nextCycle();

        // ---------------- outstanding limit ----------------
        $display("[TB] outstanding limit");
        applyStimulus(1'b1, 1'b0, 32'h1C00_0000, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t3_addr_ok_a", 32'(sram_bus.inst_sram_addr_ok), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h1C00_0004, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t3_send_addr_ok", 32'(sram_bus.inst_sram_addr_ok), 32'd0);
        nextCycle();
        sample();
        checkOutput("t3_addr_ok_b", 32'(sram_bus.inst_sram_addr_ok), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h1C00_0008, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t3_ar_b_araddr", axi_bus.araddr, 32'h1C00_0004);
        checkOutput("t3_ar_b_addr_ok", 32'(sram_bus.inst_sram_addr_ok), 32'd0);
        nextCycle();
        for (int i = 0; i < 2; i++) begin
            sample();
            checkOutput("t3_full_addr_ok", 32'(sram_bus.inst_sram_addr_ok), 32'd0);
            checkOutput("t3_full_cnt", 32'(dut.cnt), 32'd2);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 32'h1C00_0008, 1'b1, 1'b1, 32'h1111_1111);
        sample();
        checkOutput("t3_rbeat_addr_ok", 32'(sram_bus.inst_sram_addr_ok), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h1C00_0008, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t3_addr_ok_c", 32'(sram_bus.inst_sram_addr_ok), 32'd1);
        checkOutput("t3_d1_data_ok", 32'(sram_bus.inst_sram_data_ok), 32'd1);
        checkOutput("t3_d1_rdata", sram_bus.inst_sram_rdata, 32'h1111_1111);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2222_2222);
        sample();
        checkOutput("t3_ar_c_araddr", axi_bus.araddr, 32'h1C00_0008);
        checkOutput("t3_ar_c_cnt", 32'(dut.cnt), 32'd2);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3333_3333);
        sample();
        checkOutput("t3_d2_rdata", sram_bus.inst_sram_rdata, 32'h2222_2222);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t3_d3_data_ok", 32'(sram_bus.inst_sram_data_ok), 32'd1);
        checkOutput("t3_d3_rdata", sram_bus.inst_sram_rdata, 32'h3333_3333);
        checkOutput("t3_d3_cnt", 32'(dut.cnt), 32'd0);
        nextCycle();

        // ---------------- write request rejected ----------------
        $display("[TB] write request");
        applyStimulus(1'b1, 1'b1, 32'h1C00_0030, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sample();
            checkOutput("t4_wr_addr_ok", 32'(sram_bus.inst_sram_addr_ok), 32'd0);
            checkOutput("t4_wr_arvalid", 32'(axi_bus.arvalid), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // ---------------- R and accept in the same cycle ----------------
        $display("[TB] simultaneous accept and return");
        applyStimulus(1'b1, 1'b0, 32'h1C00_0020, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t5_addr_ok_a", 32'(sram_bus.inst_sram_addr_ok), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h1C00_0024, 1'b1, 1'b1, 32'hCAFE_F00D);
        sample();
        checkOutput("t5_both_addr_ok", 32'(sram_bus.inst_sram_addr_ok), 32'd1);
        checkOutput("t5_both_rready", 32'(axi_bus.rready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t5_cnt_kept", 32'(dut.cnt), 32'd1);
        checkOutput("t5_data_ok", 32'(sram_bus.inst_sram_data_ok), 32'd1);
        checkOutput("t5_rdata", sram_bus.inst_sram_rdata, 32'hCAFE_F00D);
        checkOutput("t5_araddr", axi_bus.araddr, 32'h1C00_0024);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0BAD_BEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        checkOutput("t5_d2_rdata", sram_bus.inst_sram_rdata, 32'h0BAD_BEEF);
        checkOutput("t5_d2_cnt", 32'(dut.cnt), 32'd0);
        nextCycle();

        // ---------------- reset mid-operation ----------------
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 32'h1C00_0040, 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h1C00_0044, 1'b1, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        sample();
        checkOutput("t6_pre_cnt", 32'(dut.cnt), 32'd2);
        checkOutput("t6_pre_arvalid", 32'(axi_bus.arvalid), 32'd1);
        resetn = 1'b0;
        nextCycle();
        sample();
        checkOutput("t6_rst_arvalid", 32'(axi_bus.arvalid), 32'd0);
        checkOutput("t6_rst_araddr", axi_bus.araddr, 32'h0);
        checkOutput("t6_rst_rready", 32'(axi_bus.rready), 32'd0);
        checkOutput("t6_rst_rdata", sram_bus.inst_sram_rdata, 32'h0);
        resetn = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        sample();
        checkOutput("t6_spur_rready", 32'(axi_bus.rready), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        sample();
        checkOutput("t6_spur_data_ok", 32'(sram_bus.inst_sram_data_ok), 32'd0);
        checkOutput("t6_spur_rdata", sram_bus.inst_sram_rdata, 32'h0);
        checkOutput("t6_spur_cnt", 32'(dut.cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
